// File: rtl/cpu_bus_responder.sv
// Two-phase multiplexed CPU bus responder: rebuilds address/rw/write data and issues held mem_re/mem_we requests.
// Read latency 1+N clocks fall-to-drive; memory stalls via mem_ready, an unfinished access at the next rise sets late_err.
module cpu_bus_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        phase,
  input  logic [7:0]  bus_addr_in,
  input  logic [7:0]  bus_io_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        late_err
);

  typedef enum logic [2:0] {IDLE, LO, RD, DRV, WR, WREQ} state_t;

  state_t     state;
  logic       phase_q;
  logic       rw;
  logic [7:0] a_lo;
  logic       rise;
  logic       fall;

  assign rise = phase & ~phase_q;
  assign fall = ~phase & phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase_q      <= 1'b0;
      rw           <= 1'b0;
      a_lo         <= 8'h00;
      bus_data_out <= 8'h00;
      bus_data_oe  <= 1'b0;
      mem_addr     <= 16'h0000;
      mem_wdata    <= 8'h00;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      late_err     <= 1'b0;
    end else begin
      phase_q <= phase;
      if (rise) begin
        // A request still pending when the next bus cycle starts is abandoned and flagged.
        if (((state == RD) || (state == WREQ)) && !mem_ready)
          late_err <= 1'b1;
        a_lo        <= bus_addr_in;
        rw          <= bus_io_in[0];
        bus_data_oe <= 1'b0;
        mem_re      <= 1'b0;
        mem_we      <= 1'b0;
        state       <= LO;
      end else begin
        case (state)
          LO: begin
            if (fall) begin
              mem_addr <= {bus_addr_in, a_lo};
              if (rw) begin
                state <= WR;
              end else begin
                mem_re <= 1'b1;
                state  <= RD;
              end
            end
          end
          RD: begin
            if (mem_ready) begin
              bus_data_out <= mem_rdata;
              bus_data_oe  <= 1'b1;
              mem_re       <= 1'b0;
              state        <= DRV;
            end
          end
          // Write data is sampled one clock after the fall so the pins have settled.
          WR: begin
            mem_wdata <= bus_io_in;
            mem_we    <= 1'b1;
            state     <= WREQ;
          end
          WREQ: begin
            if (mem_ready) begin
              mem_we <= 1'b0;
              state  <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: reads, writes, late completion, back-to-back and async reset.
module tb_cpu_bus_responder;

  logic        clk;
  logic        rst;
  logic        phase;
  logic [7:0]  bus_addr_in;
  logic [7:0]  bus_io_in;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        late_err;

  int vectors = 0;
  int miscompares = 0;

  cpu_bus_responder dut (
    .clk(clk), .rst(rst), .phase(phase), .bus_addr_in(bus_addr_in), .bus_io_in(bus_io_in),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .late_err(late_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requests must be mutually exclusive on every cycle.
  always @(negedge clk) begin
    vectors++;
    if (mem_re && mem_we) begin
      miscompares++;
      $display("FAIL re_we_exclusive: re=%b we=%b want not both 1", mem_re, mem_we);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; phase = 1'b0; bus_addr_in = 8'h00; bus_io_in = 8'h00;
    mem_rdata = 8'h00; mem_ready = 1'b0;
    cyc(); cyc();
    vectors++; if (bus_data_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe: got %b want 0", bus_data_oe); end
    vectors++; if (bus_data_out !== 8'h00) begin miscompares++; $display("FAIL rst_dout: got %h want 00", bus_data_out); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
    vectors++; if (mem_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata: got %h want 00", mem_wdata); end
    vectors++; if ({mem_re, mem_we, late_err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {mem_re, mem_we, late_err}); end
    rst = 1'b0;
    cyc();
    vectors++; if ({mem_re, mem_we, bus_data_oe} !== 3'b000) begin miscompares++; $display("FAIL idle_quiet: got %b want 000", {mem_re, mem_we, bus_data_oe}); end
  endtask

  task automatic test_read_zero_wait();
    phase = 1'b1; bus_addr_in = 8'h34; bus_io_in = 8'h00;
    cyc();
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL rd_lo_re: got %b want 0", mem_re); end
    phase = 1'b0; bus_addr_in = 8'h12;
    cyc();
    vectors++; if (mem_re !== 1'b1) begin miscompares++; $display("FAIL rd_re: got %b want 1", mem_re); end
    vectors++; if (mem_addr !== 16'h1234) begin miscompares++; $display("FAIL rd_addr: got %h want 1234", mem_addr); end
    vectors++; if (bus_data_oe !== 1'b0) begin miscompares++; $display("FAIL rd_oe_early: got %b want 0", bus_data_oe); end
    mem_ready = 1'b1; mem_rdata = 8'hA9;
    cyc();
    mem_ready = 1'b0; mem_rdata = 8'h00;
    vectors++; if (bus_data_oe !== 1'b1) begin miscompares++; $display("FAIL rd_oe: got %b want 1", bus_data_oe); end
    vectors++; if (bus_data_out !== 8'hA9) begin miscompares++; $display("FAIL rd_dout: got %h want a9", bus_data_out); end
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL rd_re_drop: got %b want 0", mem_re); end
    // Stray ready while driving must be ignored.
    mem_ready = 1'b1; mem_rdata = 8'h55;
    cyc(); cyc();
    mem_ready = 1'b0;
    vectors++; if ({bus_data_oe, bus_data_out} !== {1'b1, 8'hA9}) begin miscompares++; $display("FAIL rd_hold: got %b/%h want 1/a9", bus_data_oe, bus_data_out); end
  endtask

  task automatic test_write_wait();
    phase = 1'b1; bus_addr_in = 8'hFE; bus_io_in = 8'h01;
    cyc();
    vectors++; if (bus_data_oe !== 1'b0) begin miscompares++; $display("FAIL wr_oe_release: got %b want 0", bus_data_oe); end
    phase = 1'b0; bus_addr_in = 8'h01; bus_io_in = 8'h5C;
    cyc();
    vectors++; if ({mem_addr, mem_we} !== {16'h01FE, 1'b0}) begin miscompares++; $display("FAIL wr_settle: got %h/%b want 01fe/0", mem_addr, mem_we); end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h01FE, 8'h5C}) begin
        miscompares++; $display("FAIL wr_req_cyc%0d: got %b/%h/%h want 1/01fe/5c", i, mem_we, mem_addr, mem_wdata);
      end
      vectors++; if (bus_data_oe !== 1'b0) begin miscompares++; $display("FAIL wr_oe_cyc%0d: got %b want 0", i, bus_data_oe); end
      if (i == 3) mem_ready = 1'b1;
    end
    cyc();
    mem_ready = 1'b0;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_done: got %b want 0", mem_we); end
    cyc(); cyc();
    vectors++; if ({mem_re, mem_we, bus_data_oe, late_err} !== 4'b0000) begin miscompares++; $display("FAIL wr_idle: got %b want 0000", {mem_re, mem_we, bus_data_oe, late_err}); end
  endtask

  task automatic test_late_read();
    phase = 1'b1; bus_addr_in = 8'h78; bus_io_in = 8'h00;
    cyc();
    phase = 1'b0; bus_addr_in = 8'h9A;
    cyc(); cyc(); cyc(); cyc();
    vectors++; if ({mem_re, mem_addr, late_err} !== {1'b1, 16'h9A78, 1'b0}) begin miscompares++; $display("FAIL late_pending: got %b/%h/%b want 1/9a78/0", mem_re, mem_addr, late_err); end
    phase = 1'b1; bus_addr_in = 8'hBC; bus_io_in = 8'h01;
    cyc();
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL late_re_drop: got %b want 0", mem_re); end
    vectors++; if (late_err !== 1'b1) begin miscompares++; $display("FAIL late_err_set: got %b want 1", late_err); end
    phase = 1'b0; bus_addr_in = 8'h00; bus_io_in = 8'h3E;
    cyc();
    vectors++; if (mem_addr !== 16'h00BC) begin miscompares++; $display("FAIL late_new_lo: got %h want 00bc", mem_addr); end
    cyc();
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    vectors++; if ({mem_we, mem_wdata, late_err} !== {1'b0, 8'h3E, 1'b1}) begin miscompares++; $display("FAIL late_sticky: got %b/%h/%b want 0/3e/1", mem_we, mem_wdata, late_err); end
  endtask

  task automatic test_back_to_back();
    phase = 1'b1; bus_addr_in = 8'h10; bus_io_in = 8'h00;
    cyc();
    phase = 1'b0; bus_addr_in = 8'h00;
    cyc();
    vectors++; if ({mem_re, mem_addr} !== {1'b1, 16'h0010}) begin miscompares++; $display("FAIL b2b_rd: got %b/%h want 1/0010", mem_re, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 8'h3C;
    cyc();
    mem_ready = 1'b0;
    cyc();
    vectors++; if ({bus_data_oe, bus_data_out} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL b2b_drv: got %b/%h want 1/3c", bus_data_oe, bus_data_out); end
    phase = 1'b1; bus_addr_in = 8'h11; bus_io_in = 8'h01;
    cyc();
    vectors++; if ({bus_data_oe, mem_re, mem_we} !== 3'b000) begin miscompares++; $display("FAIL b2b_release: got %b want 000", {bus_data_oe, mem_re, mem_we}); end
    phase = 1'b0; bus_addr_in = 8'h00; bus_io_in = 8'h77;
    cyc(); cyc();
    vectors++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b10, 16'h0011, 8'h77}) begin miscompares++; $display("FAIL b2b_wr: got %b%b/%h/%h want 10/0011/77", mem_we, mem_re, mem_addr, mem_wdata); end
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_done: got %b want 0", mem_we); end
  endtask

  task automatic test_async_reset();
    phase = 1'b1; bus_addr_in = 8'h20; bus_io_in = 8'h01;
    cyc();
    phase = 1'b0; bus_addr_in = 8'h40; bus_io_in = 8'hAA;
    cyc(); cyc();
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL ar_we_before: got %b want 1", mem_we); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL ar_we_async: got %b want 0", mem_we); end
    vectors++; if (late_err !== 1'b0) begin miscompares++; $display("FAIL ar_late_clear: got %b want 0", late_err); end
    phase = 1'b1; bus_addr_in = 8'h55; bus_io_in = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    phase = 1'b0; bus_addr_in = 8'h66;
    cyc();
    vectors++; if ({mem_re, mem_addr, late_err} !== {1'b1, 16'h6655, 1'b0}) begin miscompares++; $display("FAIL ar_recapture: got %b/%h/%b want 1/6655/0", mem_re, mem_addr, late_err); end
    mem_ready = 1'b1; mem_rdata = 8'h81;
    cyc();
    mem_ready = 1'b0;
    vectors++; if ({bus_data_oe, bus_data_out} !== {1'b1, 8'h81}) begin miscompares++; $display("FAIL ar_read: got %b/%h want 1/81", bus_data_oe, bus_data_out); end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_late_read();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
